// File: rtl/frost32_mem_responder_pkg.sv
// Shared Frost32 memory-responder types: CPU access enums, responder state encoding,
// and helpers for the byte-lane rules used at the completion edge.
`ifndef MSB_POS__FROST32_MEM_RESP_STATE
`define MSB_POS__FROST32_MEM_RESP_STATE 1
`endif

package frost32_mem_responder_pkg;

  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } DataInoutAccessType;

  typedef enum logic [1:0] {
    Dias32  = 2'd0,
    Dias16  = 2'd1,
    Dias8   = 2'd2,
    DiasBad = 2'd3
  } DataInoutAccessSize;

  localparam int RespStateMsb = `MSB_POS__FROST32_MEM_RESP_STATE;

  typedef logic [RespStateMsb:0] StRespState;

  localparam logic [RespStateMsb:0] StRespIdle = 2'd0;
  localparam logic [RespStateMsb:0] StRespWait = 2'd1;
  localparam logic [RespStateMsb:0] StRespDone = 2'd2;

  function automatic logic access_trapped(input DataInoutAccessSize size, input logic [1:0] lo);
    case (size)
      Dias32:  access_trapped = (lo != 2'b00);
      Dias16:  access_trapped = lo[0];
      Dias8:   access_trapped = 1'b0;
      default: access_trapped = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input DataInoutAccessSize size, input logic [1:0] lo);
    case (size)
      Dias32:  lane_enables = 4'b1111;
      Dias16:  lane_enables = lo[1] ? 4'b1100 : 4'b0011;
      Dias8:   lane_enables = 4'b0001 << lo;
      default: lane_enables = 4'b0000;
    endcase
  endfunction

  // Replicate narrow write data across all lanes; the enables pick the live ones.
  function automatic logic [31:0] lane_wdata(input DataInoutAccessSize size, input logic [31:0] data);
    case (size)
      Dias16:  lane_wdata = {2{data[15:0]}};
      Dias8:   lane_wdata = {4{data[7:0]}};
      default: lane_wdata = data;
    endcase
  endfunction

  function automatic logic [31:0] lane_rdata(input DataInoutAccessSize size, input logic [1:0] lo,
                                             input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {lo, 3'b000};
    case (size)
      Dias16:  lane_rdata = {16'h0000, shifted[15:0]};
      Dias8:   lane_rdata = {24'h000000, shifted[7:0]};
      default: lane_rdata = word;
    endcase
  endfunction

endpackage

// File: rtl/frost32_byte_lane_ram.sv
// Single-port 2^ADDR_WIDTH x 32 RAM with per-byte write enables and a registered read.
// Read data appears one edge after the address; contents are never reset.
module frost32_byte_lane_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            byte_en,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (byte_en[k]) mem[addr][8*k +: 8] <= wr_data[8*k +: 8];
    end
    rd_data <= mem[addr];
  end

endmodule

// File: rtl/frost32_mem_responder.sv
// Frost32 data-port responder: fixed LATENCY wait states then a one-cycle completion,
// with misaligned/bad-size accesses trapped (no write, data_out cleared, bus_error pulse).
module frost32_mem_responder
  import frost32_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_mem_access,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        data_inout_access_type,
  input  logic [1:0]  data_inout_access_size,
  output logic [31:0] data_out,
  output logic        wait_for_mem,
  output logic        bus_error
);

  localparam logic [3:0] LatCount = 4'(LATENCY);

  StRespState            state;
  logic [3:0]            count;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [1:0]            lo_q;
  logic [31:0]           wdata_q;
  DataInoutAccessType    type_q;
  DataInoutAccessSize    size_q;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [3:0]            ram_be;
  logic [31:0]           ram_rdata;
  logic                  access_edge;
  logic                  trap_q;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

  assign wait_for_mem = (state == StRespIdle) ? req_mem_access : (state == StRespWait);
  assign access_edge  = (state == StRespWait) && (count == 4'd1);
  assign trap_q       = access_trapped(size_q, lo_q);

  // The RAM reads every cycle; in Idle it looks at the live request address so that
  // even a single wait state has the word ready when the access completes.
  assign ram_addr = (state == StRespIdle) ? addr[ADDR_WIDTH+1:2] : word_q;
  assign ram_be   = (access_edge && type_q == DiatWrite && !trap_q) ? lane_enables(size_q, lo_q)
                                                                     : 4'b0000;

  frost32_byte_lane_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .addr   (ram_addr),
    .byte_en(ram_be),
    .wr_data(lane_wdata(size_q, wdata_q)),
    .rd_data(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StRespIdle;
      count     <= 4'd0;
      data_out  <= 32'h0;
      bus_error <= 1'b0;
      word_q    <= '0;
      lo_q      <= 2'b00;
      wdata_q   <= 32'h0;
      type_q    <= DiatRead;
      size_q    <= Dias32;
    end else begin
      bus_error <= 1'b0;
      case (state)
        StRespIdle: begin
          if (req_mem_access) begin
            word_q  <= addr[ADDR_WIDTH+1:2];
            lo_q    <= addr[1:0];
            wdata_q <= data_in;
            type_q  <= DataInoutAccessType'(data_inout_access_type);
            size_q  <= DataInoutAccessSize'(data_inout_access_size);
            count   <= LatCount;
            state   <= StRespWait;
          end
        end
        StRespWait: begin
          count <= count - 4'd1;
          if (access_edge) begin
            state     <= StRespDone;
            bus_error <= trap_q;
            if (trap_q) data_out <= 32'h0;
            else if (type_q == DiatRead) data_out <= lane_rdata(size_q, lo_q, ram_rdata);
          end
        end
        default: state <= StRespIdle;
      endcase
    end
  end

endmodule
